// File: rtl/regdump_pkg.sv
// Shared definitions for the register-file dump reader.
// FSM state encoding, frame header default and per-register byte count.
package regdump_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HEADER = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_SEND   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [7:0] HEADER_BYTE_DEF = 8'hA5;

    localparam int unsigned BYTES_PER_REG = 5;

    // Byte-counter value of the final byte of a register record.
    localparam logic [2:0] LAST_BYTE = 3'(BYTES_PER_REG - 1);

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Valid/ready byte stream from the dump reader to the UART transmitter.
// master drives tx_data/tx_valid, slave returns tx_ready.
interface regfile_dump_reader_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/regfile_dump_reader.sv
// Debug engine: walks FIRST_REG..LAST_REG over a read port and streams
// a frame (header, then index + data MSB-first per register) to the UART.
// Ports: clk, reset (async, active-low), start, busy, done,
//        rd_addr/rd_data (register-file read port), tx (byte stream master).
module regfile_dump_reader
    import regdump_pkg::*;
#(
    parameter int unsigned FIRST_REG   = 1,
    parameter int unsigned LAST_REG    = 31,
    parameter logic [7:0]  HEADER_BYTE = HEADER_BYTE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    regfile_dump_reader_if.master tx
);

    localparam logic [4:0] FIRST = 5'(FIRST_REG);
    localparam logic [4:0] LAST  = 5'(LAST_REG);

    logic [2:0]  state_q, state_d;
    logic [4:0]  idx_q,   idx_d;
    logic [4:0]  addr_q,  addr_d;
    logic [2:0]  cnt_q,   cnt_d;
    logic [39:0] shift_q, shift_d;

    logic valid;
    logic hs;

    // Outputs are pure decodes of registered state, so an async reset
    // removes tx_valid/busy in the same instant.
    assign valid = (state_q == ST_HEADER) || (state_q == ST_SEND);
    assign hs    = valid && tx.tx_ready;

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign rd_addr  = addr_q;
    assign tx.tx_valid = valid;

    always_comb begin
        tx.tx_data = 8'h00;
        unique case (state_q)
            ST_HEADER: tx.tx_data = HEADER_BYTE;
            ST_SEND:   tx.tx_data = shift_q[39:32];
            default:   tx.tx_data = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_HEADER;
                    idx_d   = FIRST;
                end
            end
            ST_HEADER: begin
                if (hs) begin
                    state_d = ST_LOAD;
                    addr_d  = idx_q;
                end
            end
            ST_LOAD: begin
                // rd_data is combinational from addr_q == idx_q here.
                shift_d = {3'b000, idx_q, rd_data};
                cnt_d   = 3'd0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (hs) begin
                    if (cnt_q == LAST_BYTE) begin
                        if (idx_q == LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            idx_d   = idx_q + 5'd1;
                            addr_d  = idx_q + 5'd1;
                            state_d = ST_LOAD;
                        end
                    end else begin
                        shift_d = {shift_q[31:0], 8'h00};
                        cnt_d   = cnt_q + 3'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                addr_d  = FIRST;
            end
            default: begin
                state_d = ST_IDLE;
                addr_d  = FIRST;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= FIRST;
            addr_q  <= FIRST;
            cnt_q   <= 3'd0;
            shift_q <= 40'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader.
// Two instances: default range and FIRST_REG=28..LAST_REG=29.
module tb_regfile_dump_reader;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        int          ridx;
        logic [39:0] bytes;
    } probe_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic        rdy = 1'b1;
    logic        busy, done, busy2, done2;
    logic [4:0]  rd_addr, rd_addr2;
    logic [31:0] rd_data, rd_data2;

    logic [31:0] regs  [32];
    logic [31:0] mregs [32];

    int ready_pct = 100;
    int pass = 0;
    int total = 0;
    int cyc = 0;
    int start_edge = 0, start2_edge = 0;
    int done_edge = 0, done2_edge = 0;
    int done_cnt = 0, done2_cnt = 0;
    int busy_cnt = 0;
    bit prev_stall = 0;
    logic [7:0] prev_data = 8'h00;

    byte_q_t got, got2, exp1, exp2;

    regfile_dump_reader_if txa ();
    regfile_dump_reader_if txb ();

    assign txa.tx_ready = rdy;
    assign txb.tx_ready = 1'b1;
    assign rd_data  = regs[rd_addr];
    assign rd_data2 = regs[rd_addr2];

    regfile_dump_reader dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .tx      (txa.master)
    );

    regfile_dump_reader #(
        .FIRST_REG (28),
        .LAST_REG  (29)
    ) dut2 (
        .clk     (clk),
        .reset   (reset),
        .start   (start2),
        .busy    (busy2),
        .done    (done2),
        .rd_addr (rd_addr2),
        .rd_data (rd_data2),
        .tx      (txb.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
        total++;
        if (a === e) pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, a, e);
    endtask

    // Random transmitter back-pressure, changed away from the clock edge.
    initial forever begin
        @(negedge clk);
        if (ready_pct >= 100) rdy = 1'b1;
        else rdy = ($urandom_range(0, 99) < ready_pct);
    end

    // Monitor: byte capture, done/busy accounting, stall stability.
    initial forever begin
        @(posedge clk);
        if (reset) begin
            if (prev_stall)
                chk("stall_hold", {txa.tx_valid, txa.tx_data},
                    {1'b1, prev_data});
            prev_stall = txa.tx_valid && !txa.tx_ready;
            prev_data  = txa.tx_data;
            if (txa.tx_valid && txa.tx_ready) got.push_back(txa.tx_data);
            if (txb.tx_valid && txb.tx_ready) got2.push_back(txb.tx_data);
            if (start && !busy) start_edge = cyc;
            if (start2 && !busy2) start2_edge = cyc;
            if (done) begin done_cnt++; done_edge = cyc; end
            if (done2) begin done2_cnt++; done2_edge = cyc; end
            if (busy) busy_cnt++;
        end else begin
            prev_stall = 1'b0;
        end
        cyc++;
    end

    // Reference frame: header, then index and big-endian data per register.
    function automatic byte_q_t frame(input int f, input int l);
        byte_q_t q;
        q.push_back(8'hA5);
        for (int k = f; k <= l; k++) begin
            q.push_back(8'(k));
            for (int b = 3; b >= 0; b--) q.push_back(mregs[k][8*b +: 8]);
        end
        return q;
    endfunction

    task automatic cmp(input string nm, input byte_q_t g, input byte_q_t e);
        int nmis;
        nmis = 0;
        chk({nm, "_len"}, 64'(g.size()), 64'(e.size()));
        for (int i = 0; i < e.size(); i++)
            if (i >= g.size() || g[i] !== e[i]) nmis++;
        chk({nm, "_bytes"}, 64'(nmis), 64'd0);
    endtask

    function automatic logic [39:0] rec(input byte_q_t g, input int ridx);
        logic [39:0] r;
        int base;
        r = '0;
        base = 1 + 5 * (ridx - 1);
        for (int i = 0; i < 5; i++)
            if (base + i < g.size()) r[39-8*i -: 8] = g[base + i];
        return r;
    endfunction

    task automatic default_regs();
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        regs[28] = 32'h00001800;
        regs[29] = 32'h00000ffc;
        for (int i = 0; i < 32; i++) mregs[i] = regs[i];
    endtask

    task automatic kick(input bit both);
        got.delete();
        got2.delete();
        done_cnt = 0;
        done2_cnt = 0;
        busy_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        start2 = both;
        @(negedge clk);
        start = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_cycle(input int n);
        for (int i = 0; i < 3000 && (cyc - start_edge) < n; i++)
            @(negedge clk);
    endtask

    task automatic finish_run(input int extra);
        for (int i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clk);
        chk("done_seen", 64'(done_cnt), 64'd1);
        repeat (extra) @(negedge clk);
    endtask

    probe_t tbl[5];

    initial begin
        tbl[0] = '{1,  40'h01_00000000};
        tbl[1] = '{5,  40'h05_00000000};
        tbl[2] = '{28, 40'h1C_00001800};
        tbl[3] = '{29, 40'h1D_00000FFC};
        tbl[4] = '{31, 40'h1F_00000000};

        default_regs();
        repeat (3) @(negedge clk);
        chk("rst_busy",   64'(busy), 64'd0);
        chk("rst_done",   64'(done), 64'd0);
        chk("rst_valid",  64'(txa.tx_valid), 64'd0);
        chk("rst_data",   64'(txa.tx_data), 64'h00);
        chk("rst_addr",   64'(rd_addr), 64'd1);
        chk("rst_addr2",  64'(rd_addr2), 64'd28);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Full default dump on both instances with no back-pressure.
        ready_pct = 100;
        kick(1'b1);
        finish_run(4);
        exp1 = frame(1, 31);
        exp2 = frame(28, 29);
        cmp("dflt", got, exp1);
        cmp("short", got2, exp2);
        chk("done_cyc",  64'(done_edge - start_edge), 64'd188);
        chk("done2_cyc", 64'(done2_edge - start2_edge), 64'd14);
        chk("busy_cyc",  64'(busy_cnt), 64'd188);
        chk("done2_cnt", 64'(done2_cnt), 64'd1);
        for (int i = 0; i < 5; i++)
            chk($sformatf("probe_r%0d", tbl[i].ridx),
                64'(rec(got, tbl[i].ridx)), 64'(tbl[i].bytes));
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_addr", 64'(rd_addr), 64'd1);

        // Random back-pressure: same stream, stall stability in monitor.
        ready_pct = 50;
        kick(1'b0);
        finish_run(4);
        cmp("stall", got, exp1);

        // Random register contents and back-pressure.
        for (int k = 1; k < 32; k++) regs[k] = $urandom;
        for (int i = 0; i < 32; i++) mregs[i] = regs[i];
        ready_pct = 40;
        kick(1'b0);
        finish_run(4);
        cmp("rand", got, frame(1, 31));

        // Writes around LOAD: r3 loaded at 14, r5 loaded at 26.
        default_regs();
        ready_pct = 100;
        kick(1'b0);
        wait_cycle(20);
        regs[3] = 32'h12345678;
        regs[5] = 32'hDEADBEEF;
        mregs[5] = 32'hDEADBEEF;
        finish_run(4);
        cmp("wr", got, frame(1, 31));
        chk("wr_r5", 64'(rec(got, 5)), 64'h05_DEADBEEF);
        chk("wr_r3", 64'(rec(got, 3)), 64'h03_00000000);

        // start during SEND of r10 (cycles 57..61) is ignored.
        default_regs();
        kick(1'b0);
        wait_cycle(58);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_run(200);
        chk("nostart_done", 64'(done_cnt), 64'd1);
        cmp("nostart", got, exp1);

        // Reset during SEND of r7 byte 2 (cycle 41), then a fresh dump.
        kick(1'b0);
        wait_cycle(41);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(txa.tx_valid), 64'd0);
        chk("mid_rst_busy",  64'(busy), 64'd0);
        chk("mid_rst_addr",  64'(rd_addr), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        kick(1'b0);
        finish_run(4);
        cmp("after_rst", got, exp1);
        chk("after_rst_cyc", 64'(done_edge - start_edge), 64'd188);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
